// File: rtl/mp_pkg.sv
// Shared state/opcode encodings, widths, control bundle and MEM timeout limit
// for the multicycle sequencer.
package mp_pkg;

    localparam int unsigned STATE_W           = 3;
    localparam int unsigned OP_W              = 2;
    localparam int unsigned CNT_W             = 16;
    localparam int unsigned WAIT_W            = 4;
    localparam int unsigned MEM_TIMEOUT_LIMIT = 16;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 2'b00,
        OP_LOAD  = 2'b01,
        OP_STORE = 2'b10,
        OP_BEQ   = 2'b11
    } op_t;

    // Datapath and handshake controls produced by the state decoder
    typedef struct packed {
        logic instr_ready;
        logic ir_write;
        logic pc_write;
        logic pc_src;
        logic reg_dst;
        logic reg_write;
        logic alu_src;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_op;
    } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational control decode from current state and latched opcode; zero,
// instr_valid and mem_ready only qualify the single-cycle strobes.
module seq_decode
    import mp_pkg::*;
(
    input  state_t state,
    input  op_t    op_q,
    input  logic   zero,
    input  logic   instr_valid,
    input  logic   mem_ready,
    output ctrl_t  ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state)
            S_FETCH: begin
                ctrl_c.instr_ready = 1'b1;
                ctrl_c.ir_write    = instr_valid;
            end
            S_EXEC: begin
                ctrl_c.alu_src = (op_q == OP_LOAD) || (op_q == OP_STORE);
                ctrl_c.alu_op  = (op_q == OP_ADD);
                ctrl_c.branch  = (op_q == OP_BEQ);
                if (op_q == OP_BEQ) begin
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = zero;
                end
            end
            S_MEM: begin
                ctrl_c.mem_read  = (op_q == OP_LOAD);
                ctrl_c.mem_write = (op_q == OP_STORE);
                ctrl_c.pc_write  = (op_q == OP_STORE) && mem_ready;
            end
            S_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.reg_dst    = (op_q == OP_ADD);
                ctrl_c.mem_to_reg = (op_q == OP_LOAD);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Five-state multicycle instruction sequencer with retired-instruction count.
// Define SEQ_MEM_TIMEOUT_EN to abort MEM after 16 cycles without mem_ready.
module multicycle_sequencer
    import mp_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [OP_W-1:0]    op,
    input  logic               instr_valid,
    input  logic               mem_ready,
    input  logic               zero,
    output logic               instr_ready,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               alu_src,
    output logic               branch,
    output logic               mem_read,
    output logic               mem_write,
    output logic               mem_to_reg,
    output logic               alu_op,
`ifdef SEQ_MEM_TIMEOUT_EN
    output logic               mem_timeout,
`endif
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   instr_count
);

    state_t             state_q, state_d;
    op_t                op_q, op_d;
    logic [CNT_W-1:0]   instr_count_q, instr_count_d;
    logic               retire_c;
    ctrl_t              ctrl_c, ctrl_out_c;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_timeout_q, mem_timeout_d;
`endif

    // Next-state, opcode capture and retire
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        retire_c      = 1'b0;
        instr_count_d = instr_count_q;
`ifdef SEQ_MEM_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    op_d    = op_t'(op);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
`ifdef SEQ_MEM_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                case (op_q)
                    OP_BEQ: begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_ADD:  state_d = S_WB;
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (op_q == OP_STORE) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT_LIMIT - 1)) begin
                    state_d       = S_FETCH;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
`endif
            end
            S_WB: begin
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (retire_c) begin
            instr_count_d = instr_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            op_q          <= OP_ADD;
            instr_count_q <= '0;
`ifdef SEQ_MEM_TIMEOUT_EN
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            instr_count_q <= instr_count_d;
`ifdef SEQ_MEM_TIMEOUT_EN
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
`endif
        end
    end

    seq_decode u_decode (
        .state       (state_q),
        .op_q        (op_q),
        .zero        (zero),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .ctrl_c      (ctrl_c)
    );

    // While reset is held no strobe may fire, even from live inputs in FETCH
    always_comb begin
        ctrl_out_c = ctrl_c;
        if (reset) begin
            ctrl_out_c             = '0;
            ctrl_out_c.instr_ready = 1'b1;
        end
    end

    assign instr_ready = ctrl_out_c.instr_ready;
    assign ir_write    = ctrl_out_c.ir_write;
    assign pc_write    = ctrl_out_c.pc_write;
    assign pc_src      = ctrl_out_c.pc_src;
    assign reg_dst     = ctrl_out_c.reg_dst;
    assign reg_write   = ctrl_out_c.reg_write;
    assign alu_src     = ctrl_out_c.alu_src;
    assign branch      = ctrl_out_c.branch;
    assign mem_read    = ctrl_out_c.mem_read;
    assign mem_write   = ctrl_out_c.mem_write;
    assign mem_to_reg  = ctrl_out_c.mem_to_reg;
    assign alu_op      = ctrl_out_c.alu_op;
    assign state       = state_q;
    assign instr_count = instr_count_q;
`ifdef SEQ_MEM_TIMEOUT_EN
    assign mem_timeout = mem_timeout_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized self-checking bench for multicycle_sequencer against a per-instruction
// model of state trace, latency, strobe counts and retire count.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  op = 2'd0;
    logic        instr_valid = 1'b0;
    logic        mem_ready = 1'b0;
    logic        zero = 1'b0;
    logic        instr_ready, ir_write, pc_write, pc_src, reg_dst, reg_write;
    logic        alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op;
    logic [2:0]  state;
    logic [15:0] instr_count;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic        mem_timeout;
`endif
    logic [10:0] ctrl;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] exp_count = 16'd0;

    assign ctrl = {ir_write, pc_write, pc_src, reg_dst, reg_write, alu_src,
                   branch, mem_read, mem_write, mem_to_reg, alu_op};

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .instr_valid (instr_valid),
        .mem_ready   (mem_ready),
        .zero        (zero),
        .instr_ready (instr_ready),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src     (alu_src),
        .branch      (branch),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .alu_op      (alu_op),
`ifdef SEQ_MEM_TIMEOUT_EN
        .mem_timeout (mem_timeout),
`endif
        .state       (state),
        .instr_count (instr_count)
    );

    // One instruction from accept to return to FETCH; start with state at FETCH, between edges
    task automatic run_instr(input logic [1:0] o, input logic z, input int nwait);
        int         lat = 0, mem_cyc = 0;
        int         rd_n = 0, wr_n = 0, rw_n = 0, pcw_n = 0, irw_n = 0;
        int         asrc_n = 0, aop_n = 0, br_n = 0;
        logic       pcs = 1'b0, rdst = 1'b0, m2r = 1'b0;
        logic [2:0] obs[$];
        logic [2:0] expq[$];
        int         exp_rd, exp_wr, exp_rw;
        logic       ok;

        expq = {3'd0, 3'd1, 3'd2};
        if (o == 2'd1 || o == 2'd2)
            for (int i = 0; i <= nwait; i++) expq.push_back(3'd3);
        if (o == 2'd0 || o == 2'd1) expq.push_back(3'd4);
        exp_rd = (o == 2'd1) ? nwait + 1 : 0;
        exp_wr = (o == 2'd2) ? nwait + 1 : 0;
        exp_rw = (o == 2'd0 || o == 2'd1) ? 1 : 0;

        do begin
            if (lat == 0) begin
                op = o; instr_valid = 1'b1; zero = z; mem_ready = 1'($urandom);
            end else begin
                op = 2'($urandom);
                instr_valid = 1'($urandom);
                zero = (state == 3'd2) ? z : 1'($urandom);
                if (state == 3'd3) begin
                    mem_ready = (mem_cyc == nwait);
                    mem_cyc++;
                end else begin
                    mem_ready = 1'($urandom);
                end
            end
            #1;
            obs.push_back(state);
            if (ir_write) irw_n++;
            if (pc_write) begin pcw_n++; pcs = pc_src; end
            if (reg_write) begin rw_n++; rdst = reg_dst; m2r = mem_to_reg; end
            if (mem_read) rd_n++;
            if (mem_write) wr_n++;
            if (alu_src) asrc_n++;
            if (alu_op) aop_n++;
            if (branch) br_n++;
            @(negedge clk);
            lat++;
        end while (state != 3'd0 && lat < 64);
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        exp_count = exp_count + 16'd1;

        ok = (obs.size() == expq.size());
        for (int i = 0; i < obs.size(); i++)
            if (ok && obs[i] !== expq[i]) ok = 1'b0;
        tests++; if (!ok) begin fails++;
            $display("FAIL trace op=%0d n=%0d: got %0d states, required %0d states %p", o, nwait, obs.size(), expq.size(), expq); end
        tests++; if (lat !== expq.size()) begin fails++;
            $display("FAIL latency op=%0d: got %0d required %0d", o, lat, expq.size()); end
        tests++; if (irw_n !== 1) begin fails++;
            $display("FAIL ir_write pulses op=%0d: got %0d required 1", o, irw_n); end
        tests++; if (pcw_n !== 1) begin fails++;
            $display("FAIL pc_write pulses op=%0d: got %0d required 1", o, pcw_n); end
        tests++; if (pcs !== ((o == 2'd3) ? z : 1'b0)) begin fails++;
            $display("FAIL pc_src op=%0d zero=%0b: got %0b", o, z, pcs); end
        tests++; if (rd_n !== exp_rd || wr_n !== exp_wr) begin fails++;
            $display("FAIL mem strobes op=%0d: rd %0d wr %0d required rd %0d wr %0d", o, rd_n, wr_n, exp_rd, exp_wr); end
        tests++; if (rw_n !== exp_rw) begin fails++;
            $display("FAIL reg_write pulses op=%0d: got %0d required %0d", o, rw_n, exp_rw); end
        if (exp_rw == 1) begin
            tests++; if (rdst !== (o == 2'd0) || m2r !== (o == 2'd1)) begin fails++;
                $display("FAIL wb muxes op=%0d: reg_dst %0b mem_to_reg %0b", o, rdst, m2r); end
        end
        tests++; if (asrc_n !== int'(o == 2'd1 || o == 2'd2) || aop_n !== int'(o == 2'd0)
                      || br_n !== int'(o == 2'd3)) begin fails++;
            $display("FAIL exec controls op=%0d: alu_src %0d alu_op %0d branch %0d", o, asrc_n, aop_n, br_n); end
        tests++; if (instr_count !== exp_count) begin fails++;
            $display("FAIL instr_count op=%0d: got %h required %h", o, instr_count, exp_count); end
    endtask

    task automatic test_reset();
        instr_valid = 1'b1;
        @(negedge clk); #1;
        tests++; if (state !== 3'd0 || instr_count !== 16'd0) begin fails++;
            $display("FAIL reset state/count: got %0d/%h required 0/0000", state, instr_count); end
        tests++; if (ctrl !== 11'd0) begin fails++;
            $display("FAIL reset controls: got %b required all zero", ctrl); end
        instr_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests++; if (instr_ready !== 1'b1 || state !== 3'd0) begin fails++;
            $display("FAIL post-reset ready: instr_ready %0b state %0d", instr_ready, state); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        op = 2'd2; instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        for (int i = 0; i < 6 && state != 3'd3; i++) @(negedge clk);
        #1;
        tests++; if (state !== 3'd3 || mem_write !== 1'b1) begin fails++;
            $display("FAIL store reach MEM: state %0d mem_write %0b", state, mem_write); end
        #1 reset = 1'b1; mem_ready = 1'b1; instr_valid = 1'b1;
        #1;
        tests++; if (state !== 3'd0 || mem_write !== 1'b0) begin fails++;
            $display("FAIL async reset: state %0d mem_write %0b required 0/0", state, mem_write); end
        @(posedge clk); #1;
        tests++; if (ctrl !== 11'd0) begin fails++;
            $display("FAIL strobes held in reset: got %b required all zero", ctrl); end
        @(negedge clk);
        reset = 1'b0; mem_ready = 1'b0; instr_valid = 1'b0;
        #1;
        tests++; if (state !== 3'd0 || instr_count !== exp_count || instr_ready !== 1'b1) begin fails++;
            $display("FAIL after mid-store reset: state %0d count %h ready %0b required 0/%h/1", state, instr_count, instr_ready, exp_count); end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        run_instr(2'd0, 1'b0, 0);
    endtask

    task automatic test_load_wait3();
        run_instr(2'd1, 1'b0, 3);
    endtask

    task automatic test_branch();
        run_instr(2'd3, 1'b1, 0);
        run_instr(2'd3, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            run_instr(2'($urandom_range(0, 3)), 1'($urandom), int'($urandom_range(0, 6)));
    endtask

    // Preload the counter near wrap instead of 65534 branch retires
    task automatic test_wrap();
        force dut.instr_count_q = 16'hFFFE;
        #1 release dut.instr_count_q;
        exp_count = 16'hFFFE;
        run_instr(2'd3, 1'b0, 0);
        run_instr(2'd3, 1'b1, 0);
        tests++; if (instr_count !== 16'h0000) begin fails++;
            $display("FAIL wrap: got %h required 0000", instr_count); end
    endtask

`ifdef SEQ_MEM_TIMEOUT_EN
    task automatic test_timeout();
        int   mem_n = 0, pcw_n = 0, cyc = 0;
        logic entered = 1'b0;
        op = 2'd2; instr_valid = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        instr_valid = 1'b0;
        while (cyc < 40 && !(entered && state != 3'd3)) begin
            #1;
            if (state == 3'd3) begin entered = 1'b1; mem_n++; end
            if (pc_write) pcw_n++;
            @(negedge clk);
            cyc++;
        end
        #1;
        tests++; if (mem_n !== 16 || state !== 3'd0) begin fails++;
            $display("FAIL timeout length: MEM cycles %0d state %0d required 16/0", mem_n, state); end
        tests++; if (mem_timeout !== 1'b1 || pcw_n !== 0 || instr_count !== exp_count) begin fails++;
            $display("FAIL timeout effects: mem_timeout %0b pc_write %0d count %h required 1/0/%h", mem_timeout, pcw_n, instr_count, exp_count); end
        @(negedge clk); #1;
        tests++; if (mem_timeout !== 1'b0) begin fails++;
            $display("FAIL timeout pulse width: mem_timeout %0b required 0", mem_timeout); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_store();
        test_rtype();
        test_load_wait3();
        test_branch();
`ifdef SEQ_MEM_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
